// File: rtl/stage_mem_access.sv
// Memory pipeline stage: M register, request/ack bus access with store steering and load extension.
// Define ALIGN_CHECK_EN to suppress misaligned accesses and add the addr_err output.
module stage_mem_access #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rt_data_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc_plus8_in,
    input  logic [31:0] ins_in,
    input  logic [31:0] grf_data_in,
    input  logic        rt_data_m_type,
    output logic [31:0] alu_result_m,
    output logic [31:0] mem_data_out,
    output logic [31:0] pc_m,
    output logic [31:0] pc_m_plus8,
    output logic [31:0] ins_m,
    output logic        mem_busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
`ifdef ALIGN_CHECK_EN
    ,
    output logic        addr_err
`endif
);

    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpLhu = 6'h25;
    localparam logic [5:0] OpSb  = 6'h28;
    localparam logic [5:0] OpSh  = 6'h29;
    localparam logic [5:0] OpSw  = 6'h2B;
    localparam logic [7:0] TimeoutLast = 8'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] ldbuf_q, ldbuf_d;
    logic        err_q, err_d;
    logic [31:0] alu_q, rt_q, pc_q, pc8_q, ins_q;

    logic        is_load, is_store, sz_word, sz_half, sgn;
    logic        misaligned, mem_op, ack;
    logic [1:0]  lane;
    logic [31:0] st_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_word  = 1'b0;
        sz_half  = 1'b0;
        sgn      = 1'b0;
        case (ins_q[31:26])
            OpLb:    begin is_load = 1'b1; sgn = 1'b1; end
            OpLh:    begin is_load = 1'b1; sz_half = 1'b1; sgn = 1'b1; end
            OpLw:    begin is_load = 1'b1; sz_word = 1'b1; end
            OpLbu:   is_load = 1'b1;
            OpLhu:   begin is_load = 1'b1; sz_half = 1'b1; end
            OpSb:    is_store = 1'b1;
            OpSh:    begin is_store = 1'b1; sz_half = 1'b1; end
            OpSw:    begin is_store = 1'b1; sz_word = 1'b1; end
            default: ;
        endcase
    end

`ifdef ALIGN_CHECK_EN
    assign misaligned = (is_load | is_store) &
                        ((sz_word & (|alu_q[1:0])) | (sz_half & alu_q[0]));
    assign addr_err   = misaligned;
`else
    assign misaligned = 1'b0;
`endif

    assign lane     = alu_q[1:0];
    assign mem_op   = (is_load | is_store) & ~misaligned;
    assign bus_req  = mem_op & ((state_q == StIdle) | (state_q == StWait));
    assign bus_we   = is_store & bus_req;
    assign mem_busy = mem_op & (state_q != StDone);
    // An ack only counts while a request is actually outstanding.
    assign ack      = bus_ack & bus_req;
    assign bus_addr = {alu_q[31:2], 2'b00};
    assign bus_err  = err_q;
    assign st_data  = rt_data_m_type ? grf_data_in : rt_q;

    always_comb begin
        bus_be    = 4'b0000;
        bus_wdata = {4{st_data[7:0]}};
        if (sz_word) begin
            bus_wdata = st_data;
        end else if (sz_half) begin
            bus_wdata = {2{st_data[15:0]}};
        end
        if (mem_op) begin
            if (sz_word)      bus_be = 4'b1111;
            else if (sz_half) bus_be = alu_q[1] ? 4'b1100 : 4'b0011;
            else              bus_be = 4'b0001 << lane;
        end
    end

    assign byte_sel = ldbuf_q[{lane, 3'b000} +: 8];
    assign half_sel = alu_q[1] ? ldbuf_q[31:16] : ldbuf_q[15:0];

    always_comb begin
        mem_data_out = 32'h0;
        if (is_load && !misaligned) begin
            if (sz_word)      mem_data_out = ldbuf_q;
            else if (sz_half) mem_data_out = {{16{sgn & half_sel[15]}}, half_sel};
            else              mem_data_out = {{24{sgn & byte_sel[7]}}, byte_sel};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ldbuf_d = ldbuf_q;
        err_d   = 1'b0;
        if (ack) ldbuf_d = bus_rdata;
        case (state_q)
            StIdle: begin
                cnt_d = 8'h0;
                if (mem_op) state_d = ack ? StDone : StWait;
            end
            StWait: begin
                if (ack) begin
                    state_d = StDone;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    ldbuf_d = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 8'h0;
            ldbuf_q <= 32'h0;
            err_q   <= 1'b0;
            alu_q   <= 32'h0;
            rt_q    <= 32'h0;
            pc_q    <= 32'h0;
            pc8_q   <= 32'h0;
            ins_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ldbuf_q <= ldbuf_d;
            err_q   <= err_d;
            if (!mem_busy) begin
                alu_q <= alu_result_in;
                rt_q  <= rt_data_in;
                pc_q  <= pc_in;
                pc8_q <= pc_plus8_in;
                ins_q <= ins_in;
            end
        end
    end

    assign alu_result_m = alu_q;
    assign pc_m         = pc_q;
    assign pc_m_plus8   = pc8_q;
    assign ins_m        = ins_q;

endmodule
